// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// Module   : fetch_ctrl_if
// Purpose  : Groups the fetch sequencer's ROM, redirect and decode signals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_ctrl_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  PC_addr;
    logic [INSTR_W-1:0] instruction;
    logic               run;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               halted;

    modport master (
        output PC_addr, out_valid, out_instr, out_pc, halted,
        input  instruction, run, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  PC_addr, out_valid, out_instr, out_pc, halted,
        output instruction, run, redirect_valid, redirect_pc, out_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Instruction-fetch sequencer with a one-entry output register.
//            Optional jump predecode: FETCH_JUMP_PREDECODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
    parameter int               ADDR_W      = 8,
    parameter int               INSTR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = 8'h00,
    parameter logic [7:0]       HALT_OPCODE = 8'hFF,
    parameter logic [7:0]       JMP_OPCODE  = 8'h08
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fetch_ctrl_if.master     bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [ADDR_W-1:0] c_pc_one = ADDR_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic               r_out_valid;
    logic [INSTR_W-1:0] r_out_instr;
    logic [ADDR_W-1:0]  r_out_pc;

    logic               w_slot_free;
    logic               w_handshake;
    logic               w_capture;
    logic [7:0]         w_opcode;
    logic [ADDR_W-1:0]  w_seq_pc;

    assign w_opcode    = bus.instruction[INSTR_W-1 -: 8];
    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_handshake = r_out_valid && bus.out_ready;
    assign w_capture   = (r_state == S_FETCH) && bus.run && w_slot_free
                         && !bus.redirect_valid;

`ifdef FETCH_JUMP_PREDECODE_EN
    assign w_seq_pc = (w_opcode == JMP_OPCODE) ? ADDR_W'(bus.instruction[23:16])
                                               : r_pc + c_pc_one;
`else
    assign w_seq_pc = r_pc + c_pc_one;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        // Redirect overrides everything else, including a pending halt
        if (bus.redirect_valid) begin
            w_pc_nxt = bus.redirect_pc;
            if (r_state == S_HALT) begin
                w_state_nxt = S_FETCH;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        w_state_nxt = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!bus.run) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_capture) begin
                        if (w_opcode == HALT_OPCODE) begin
                            w_state_nxt = S_HALT;
                        end else begin
                            w_pc_nxt = w_seq_pc;
                        end
                    end
                end
                S_HALT: begin
                    w_state_nxt = S_HALT;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // A redirect flushes the held word even when decode takes it the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
        end else if (bus.redirect_valid) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_instr <= bus.instruction;
            r_out_pc    <= r_pc;
        end else if (w_handshake) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.PC_addr   = r_pc;
    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_out_instr;
    assign bus.out_pc    = r_out_pc;
    assign bus.halted    = (r_state == S_HALT);

endmodule

`default_nettype wire
